// File: rtl/pattern_det_pkg.sv
// ============================================================================
// pattern_det_pkg : shared types and constants for the pattern detector
// Revision: 1.0
// ============================================================================
`default_nettype none

package pattern_det_pkg;

  localparam int LEN_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] ST_CFGERR  = 2'b00;
  localparam logic [1:0] ST_TARGET  = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;
  localparam logic [1:0] ST_ABORT   = 2'b11;

endpackage

`default_nettype wire

// File: rtl/pattern_match_core.sv
// ============================================================================
// pattern_match_core : serial history register with len-masked pattern compare
// Revision: 1.0
// ============================================================================
`default_nettype none

module pattern_match_core
  import pattern_det_pkg::*;
#(
  parameter int MAX_LEN = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               en,
  input  logic               x,
  input  logic               overlap,
  input  logic [LEN_W-1:0]   len,
  input  logic [MAX_LEN-1:0] pattern,
  output logic               match_hit,
  output logic [MAX_LEN-1:0] history
);

  logic [LEN_W-1:0]   r_fill;
  logic [LEN_W-1:0]   w_fill_new;
  logic [MAX_LEN-1:0] w_hist_new;
  logic [MAX_LEN-1:0] w_mask;

  // The hit is judged on the history as it will look after this bit shifts in.
  always_comb begin
    w_hist_new = {history[MAX_LEN-2:0], x};
    w_fill_new = (r_fill >= LEN_W'(MAX_LEN)) ? r_fill : r_fill + LEN_W'(1);
    w_mask     = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      w_mask[i] = (i < int'(len));
    end
    match_hit = en && (w_fill_new >= len) && (((w_hist_new ^ pattern) & w_mask) == '0);
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      history <= '0;
      r_fill  <= '0;
    end else if (en) begin
      history <= w_hist_new;
      r_fill  <= (match_hit && !overlap) ? '0 : w_fill_new;
    end
  end

endmodule

`default_nettype wire

// File: rtl/pattern_det_ctrl.sv
// ============================================================================
// pattern_det_ctrl : config handshake, run FSM, match/timeout counters
// Optional: PATTERN_DET_BITCNT_EN adds the bit_cnt output
// Revision: 1.0
// ============================================================================
`default_nettype none

module pattern_det_ctrl
  import pattern_det_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  parameter int TO_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic [CNT_W-1:0]   cfg_target,
  input  logic [TO_W-1:0]    cfg_timeout,
  input  logic               abort,
  input  logic               x,
  input  logic               x_valid,
`ifdef PATTERN_DET_BITCNT_EN
  output logic [15:0]        bit_cnt,
`endif
  output logic               busy,
  output logic               match,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               done,
  output logic [1:0]         status
);

  state_t             r_state;
  logic [MAX_LEN-1:0] r_pattern;
  logic [LEN_W-1:0]   r_len;
  logic               r_overlap;
  logic [CNT_W-1:0]   r_target;
  logic [TO_W-1:0]    r_timeout;
  logic [TO_W-1:0]    r_to_cnt;
  logic               r_hit;

  logic               w_accept;
  logic               w_cfg_err;
  logic               w_en;
  logic               w_hit;
  logic               w_cnt_inc;
  logic               w_to_hit;
  logic [MAX_LEN-1:0] w_history;

  assign w_accept  = (r_state == IDLE) && cfg_valid;
  assign w_cfg_err = (cfg_len == '0) || (cfg_len > LEN_W'(MAX_LEN)) || (cfg_target == '0);
  assign w_en      = (r_state == RUN) && x_valid;
  assign w_cnt_inc = r_hit && (match_cnt < r_target);
  assign w_to_hit  = (r_timeout != '0) && ((r_to_cnt + TO_W'(1)) == r_timeout);

  pattern_match_core #(
    .MAX_LEN (MAX_LEN)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .clr       (w_accept),
    .en        (w_en),
    .x         (x),
    .overlap   (r_overlap),
    .len       (r_len),
    .pattern   (r_pattern),
    .match_hit (w_hit),
    .history   (w_history)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      cfg_ready <= 1'b1;
      busy      <= 1'b0;
      match     <= 1'b0;
      done      <= 1'b0;
      match_cnt <= '0;
      status    <= ST_CFGERR;
      r_pattern <= '0;
      r_len     <= '0;
      r_overlap <= 1'b0;
      r_target  <= '0;
      r_timeout <= '0;
      r_to_cnt  <= '0;
      r_hit     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          done  <= 1'b0;
          match <= 1'b0;
          if (cfg_valid) begin
            r_pattern <= cfg_pattern;
            r_len     <= cfg_len;
            r_overlap <= cfg_overlap;
            r_target  <= cfg_target;
            r_timeout <= cfg_timeout;
            r_to_cnt  <= '0;
            r_hit     <= 1'b0;
            match_cnt <= '0;
            status    <= ST_CFGERR;
            cfg_ready <= 1'b0;
            if (w_cfg_err) begin
              r_state <= DONE;
              done    <= 1'b1;
            end else begin
              r_state <= RUN;
              busy    <= 1'b1;
            end
          end
        end
        RUN: begin
          r_hit    <= w_hit;
          r_to_cnt <= r_to_cnt + TO_W'(1);
          match    <= w_cnt_inc;
          if (w_cnt_inc) match_cnt <= match_cnt + CNT_W'(1);
          // Target is judged on the registered count, one cycle after it lands.
          if (abort || (match_cnt == r_target) || w_to_hit) begin
            r_state <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            if (abort)                       status <= ST_ABORT;
            else if (match_cnt == r_target)  status <= ST_TARGET;
            else                             status <= ST_TIMEOUT;
          end
        end
        DONE: begin
          done      <= 1'b0;
          match     <= 1'b0;
          r_hit     <= 1'b0;
          cfg_ready <= 1'b1;
          r_state   <= IDLE;
        end
        default: begin
          r_state   <= IDLE;
          cfg_ready <= 1'b1;
          busy      <= 1'b0;
          done      <= 1'b0;
          match     <= 1'b0;
        end
      endcase
    end
  end

`ifdef PATTERN_DET_BITCNT_EN
  always_ff @(posedge clk) begin
    if (rst || w_accept) begin
      bit_cnt <= '0;
    end else if (w_en && (bit_cnt != 16'hFFFF)) begin
      bit_cnt <= bit_cnt + 16'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_pattern_det_ctrl.sv
// ============================================================================
// tb_pattern_det_ctrl : directed and randomized runs against a bit-queue model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pattern_det_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [7:0]  cfg_pattern;
  logic [3:0]  cfg_len;
  logic        cfg_overlap;
  logic [7:0]  cfg_target;
  logic [15:0] cfg_timeout;
  logic        abort;
  logic        x;
  logic        x_valid;
  logic        busy;
  logic        match;
  logic [7:0]  match_cnt;
  logic        done;
  logic [1:0]  status;
`ifdef PATTERN_DET_BITCNT_EN
  logic [15:0] bit_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  bit sx [0:255];
  bit sv [0:255];
  bit sa [0:255];

  always #5 clk = ~clk;

  pattern_det_ctrl #(.MAX_LEN(8), .CNT_W(8), .TO_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .cfg_target  (cfg_target),
    .cfg_timeout (cfg_timeout),
    .abort       (abort),
    .x           (x),
    .x_valid     (x_valid),
`ifdef PATTERN_DET_BITCNT_EN
    .bit_cnt     (bit_cnt),
`endif
    .busy        (busy),
    .match       (match),
    .match_cnt   (match_cnt),
    .done        (done),
    .status      (status)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_stream();
    for (int i = 0; i < 256; i++) begin
      sx[i] = 1'b0;
      sv[i] = 1'b1;
      sa[i] = 1'b0;
    end
  endtask

  // Load bits 1..n of a directed stream, first bit in the MSB of s.
  task automatic load_stream(input logic [7:0] s, input int n);
    clr_stream();
    for (int i = 1; i <= n; i++) sx[i] = s[n-i];
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      x       = 1'($urandom);
      x_valid = 1'($urandom);
      tick();
      chk("idle_ready", 32'(cfg_ready), 32'd1);
      chk("idle_busy", 32'(busy), 32'd0);
    end
    x = 1'b0;
    x_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // One complete run: accept config, step the stream, compare every cycle.
  task automatic run(input logic [7:0] pat, input int len, input bit ov, input int tgt,
                     input int to, input int rst_at, input int exp_st, input int exp_cnt);
    bit q[$];
    int cnt = 0;
    bit hit_prev = 0;
    bit exited = 0;
    int st = 0;
    int bc = 0;
    bit err;
    err = (len == 0) || (len > 8) || (tgt == 0);
    cfg_valid   = 1'b1;
    cfg_pattern = pat;
    cfg_len     = 4'(len);
    cfg_overlap = ov;
    cfg_target  = 8'(tgt);
    cfg_timeout = 16'(to);
    tick();
    cfg_valid   = 1'b0;
    cfg_pattern = 8'($urandom);
    chk("acc_ready", 32'(cfg_ready), 32'd0);
    chk("acc_cnt", 32'(match_cnt), 32'd0);
    chk("acc_busy", 32'(busy), 32'(!err));
    chk("acc_done", 32'(done), 32'(err));
    if (err) begin
      chk("cfgerr_status", 32'(status), 32'd0);
      tick();
      chk("cfgerr_done_clr", 32'(done), 32'd0);
      chk("cfgerr_busy", 32'(busy), 32'd0);
      chk("cfgerr_ready", 32'(cfg_ready), 32'd1);
      return;
    end
    for (int e = 1; e < 250 && !exited; e++) begin
      bit m;
      bit h;
      x = sx[e];
      x_valid = sv[e];
      abort = sa[e];
      if (e == rst_at) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        abort = 1'b0;
        chk("rst_ready", 32'(cfg_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_match", 32'(match), 32'd0);
        chk("rst_cnt", 32'(match_cnt), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_status", 32'(status), 32'd0);
        tick();
        chk("rst_nodone", 32'(done), 32'd0);
        return;
      end
      tick();
      // Reference: pending hit lands on the count one cycle after its bit.
      m  = hit_prev && (cnt < tgt);
      st = -1;
      if (sa[e])                       st = 3;
      else if (cnt == tgt)             st = 1;
      else if (to != 0 && e == to)     st = 2;
      h = 1'b0;
      if (sv[e]) begin
        int v = 0;
        bc++;
        q.push_back(sx[e]);
        if (q.size() >= len) begin
          for (int i = 0; i < len; i++) v = (v << 1) | int'(q[q.size() - len + i]);
          h = (v == (int'(pat) & ((1 << len) - 1)));
        end
        if (h && !ov) q.delete();
        if (q.size() > 16) void'(q.pop_front());
      end
      hit_prev = h;
      cnt += int'(m);
      exited = (st >= 0);
      chk("run_match", 32'(match), 32'(m));
      chk("run_cnt", 32'(match_cnt), 32'(cnt));
      chk("run_busy", 32'(busy), 32'(!exited));
      chk("run_done", 32'(done), 32'(exited));
      if (exited) begin
        chk("end_status", 32'(status), 32'(st));
        if (exp_st >= 0) chk("end_status_exp", 32'(status), 32'(exp_st));
        if (exp_cnt >= 0) chk("end_cnt_exp", 32'(match_cnt), 32'(exp_cnt));
`ifdef PATTERN_DET_BITCNT_EN
        chk("end_bitcnt", 32'(bit_cnt), 32'(bc));
`endif
      end
    end
    abort = 1'b0;
    x_valid = 1'b0;
    if (!exited) begin
      chk("exit_bound", 32'd0, 32'd1);
      do_reset();
      return;
    end
    tick();
    chk("post_done", 32'(done), 32'd0);
    chk("post_ready", 32'(cfg_ready), 32'd1);
    chk("post_status", 32'(status), 32'(st));
    chk("post_cnt", 32'(match_cnt), 32'(cnt));
  endtask

  initial begin
    rst = 1'b1;
    cfg_valid = 1'b0;
    cfg_pattern = '0;
    cfg_len = '0;
    cfg_overlap = 1'b0;
    cfg_target = '0;
    cfg_timeout = '0;
    abort = 1'b0;
    x = 1'b0;
    x_valid = 1'b0;
    tick();
    tick();
    chk("reset_ready", 32'(cfg_ready), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_match", 32'(match), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_cnt", 32'(match_cnt), 32'd0);
    chk("reset_status", 32'(status), 32'd0);
    rst = 1'b0;
    idle(2);

    // Stream 1,0,1,0,1,1,0,1
    load_stream(8'b10101101, 8);
    run(8'b101, 3, 1'b0, 2, 0, 0, 1, 2);
    idle(2);
    load_stream(8'b10101101, 8);
    run(8'b101, 3, 1'b1, 3, 0, 0, 1, 3);
    idle(1);
    clr_stream();
    run(8'b101, 3, 1'b0, 1, 10, 0, 2, 0);
    load_stream(8'b10101101, 8);
    sa[6] = 1'b1;
    run(8'b101, 3, 1'b1, 5, 0, 0, 3, -1);
    // Final match decision and timeout land on the same edge
    load_stream(8'b10101101, 8);
    run(8'b101, 3, 1'b0, 2, 10, 0, 1, 2);
    run(8'b101, 0, 1'b0, 2, 0, 0, 0, 0);
    run(8'b101, 3, 1'b0, 0, 0, 0, 0, 0);
    run(8'b101, 9, 1'b0, 2, 0, 0, 0, 0);
    // Max-length pattern
    load_stream(8'b11001010, 8);
    run(8'b11001010, 8, 1'b0, 1, 0, 0, 1, 1);
    load_stream(8'b10100000, 8);
    run(8'b101, 3, 1'b0, 3, 0, 6, -1, -1);
    load_stream(8'b10101101, 8);
    run(8'b101, 3, 1'b0, 2, 0, 0, 1, 2);

    for (int r = 0; r < 40; r++) begin
      int len;
      int tgt;
      clr_stream();
      for (int i = 1; i < 256; i++) begin
        sx[i] = 1'($urandom);
        sv[i] = ($urandom_range(0, 3) != 0);
        sa[i] = ($urandom_range(0, 80) == 0);
      end
      len = ($urandom_range(0, 12) == 0) ? 9 * int'($urandom_range(0, 1)) : int'($urandom_range(1, 5));
      tgt = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 4));
      run(8'($urandom), len, 1'($urandom), tgt, int'($urandom_range(15, 150)), 0, -1, -1);
      idle(int'($urandom_range(0, 2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
